// File: rtl/uart_tx_scheduler_if.sv
// FIFO-side and transmitter-side handshake bundle for the UART TX scheduler.
// master = scheduler, slave = FIFO/transmitter side.
interface uart_tx_scheduler_if;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_ren;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  tx_busy,
        input  tx_done,
        output fifo_ren,
        output tx_data,
        output tx_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output tx_busy,
        output tx_done,
        input  fifo_ren,
        input  tx_data,
        input  tx_valid
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Pops bytes from the TX FIFO and offers them to the UART transmitter,
// gated by synchronised CTS, with flush handling and status reporting.
module uart_tx_scheduler #(
    parameter logic [15:0] CtsTimeout = 16'd65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cts,
    input  logic                        use_flow_control,
    input  logic                        flush,
    uart_tx_scheduler_if.master         bus,
    output logic [15:0]                 sent_count,
    output logic                        cts_stall,
    output logic                        idle
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t      state_q, state_d;
    logic        cts_meta_q, cts_meta_d;
    logic        cts_sync_q, cts_sync_d;
    logic        fifo_ren_q, fifo_ren_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [15:0] sent_count_q, sent_count_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        cts_stall_q, cts_stall_d;
    logic        idle_q, idle_d;
    logic        cts_ok;
    logic        start;

    assign cts_ok = !use_flow_control || cts_sync_q;
    assign start  = !bus.fifo_empty && cts_ok && !flush;

    // Two-stage synchroniser for the asynchronous CTS pin.
    always_comb begin
        cts_meta_d = cts;
        cts_sync_d = cts_meta_q;
    end

    // Scheduler FSM next state and registered handshake outputs.
    always_comb begin
        state_d      = state_q;
        fifo_ren_d   = 1'b0;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        sent_count_d = sent_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_data_d  = bus.fifo_rdata;
                    fifo_ren_d = 1'b1;
                    tx_valid_d = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Acceptance beats a same-cycle flush: the byte is committed.
                if (bus.tx_busy) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_SEND;
                end else if (flush) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bus.tx_done) begin
                    sent_count_d = sent_count_q + 16'd1;
                    state_d      = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
        idle_d = (state_d == ST_IDLE);
    end

    // CTS stall counter and sticky stall flag.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush || bus.fifo_empty || cts_ok) begin
            stall_cnt_d = 16'd0;
        end else if (state_q == ST_IDLE && stall_cnt_q != CtsTimeout) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush) begin
            cts_stall_d = 1'b0;
        end else begin
            cts_stall_d = cts_stall_q || (stall_cnt_d == CtsTimeout);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cts_meta_q   <= 1'b0;
            cts_sync_q   <= 1'b0;
            fifo_ren_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            sent_count_q <= 16'd0;
            stall_cnt_q  <= 16'd0;
            cts_stall_q  <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cts_meta_q   <= cts_meta_d;
            cts_sync_q   <= cts_sync_d;
            fifo_ren_q   <= fifo_ren_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            sent_count_q <= sent_count_d;
            stall_cnt_q  <= stall_cnt_d;
            cts_stall_q  <= cts_stall_d;
            idle_q       <= idle_d;
        end
    end

    assign bus.fifo_ren = fifo_ren_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign sent_count   = sent_count_q;
    assign cts_stall    = cts_stall_q;
    assign idle         = idle_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a FIFO queue and a
// simple transmitter model driven from the main test process.
module tb_uart_tx_scheduler;

    localparam int FRAME = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cts;
    logic        fc;
    logic        flush;
    logic [15:0] sent_count;
    logic        cts_stall;
    logic        idle;

    uart_tx_scheduler_if bus();

    uart_tx_scheduler #(.CtsTimeout(16'd8)) dut (
        .clk              (clk),
        .rst              (rst),
        .cts              (cts),
        .use_flow_control (fc),
        .flush            (flush),
        .bus              (bus.master),
        .sent_count       (sent_count),
        .cts_stall        (cts_stall),
        .idle             (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        fc;
        logic        cts;
        logic [15:0] exp_count;
    } vec_t;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         ren_cnt = 0;
    int         tx_cnt = 0;
    logic       tx_accept = 1'b1;
    logic [7:0] fifo_q[$];
    logic [7:0] sent_log[$];
    int         acc_cyc[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic upd_fifo();
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_rdata = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        upd_fifo();
    endtask

    // One clock: advance to the next falling edge, then update the models.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (bus.fifo_ren) begin
            ren_cnt++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        if (bus.tx_done) begin
            bus.tx_done = 1'b0;
            bus.tx_busy = 1'b0;
        end else if (bus.tx_busy) begin
            tx_cnt--;
            if (tx_cnt == 0) bus.tx_done = 1'b1;
        end else if (bus.tx_valid && tx_accept && !rst) begin
            bus.tx_busy = 1'b1;
            tx_cnt = FRAME;
            sent_log.push_back(bus.tx_data);
            acc_cyc.push_back(cyc);
        end
        upd_fifo();
    endtask

    task automatic wait_idle(input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.fifo_empty && idle && !bus.tx_valid &&
                !bus.tx_busy && !bus.tx_done) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check({nm, "_idle_timeout"}, ok, 1'b1);
    endtask

    task automatic wait_valid(input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check({nm, "_valid_timeout"}, ok, 1'b1);
    endtask

    task automatic wait_sig(input string nm, input bit want_done);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if ((want_done ? bus.tx_done : bus.tx_busy) == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({nm, "_wait_timeout"}, ok, 1'b1);
    endtask

    vec_t vecs[4];

    initial begin
        int r0;
        int l0;
        logic [15:0] c0;

        vecs[0] = '{data: 8'h3C, fc: 1'b1, cts: 1'b1, exp_count: 16'd2};
        vecs[1] = '{data: 8'h00, fc: 1'b0, cts: 1'b0, exp_count: 16'd3};
        vecs[2] = '{data: 8'hFF, fc: 1'b1, cts: 1'b1, exp_count: 16'd4};
        vecs[3] = '{data: 8'h81, fc: 1'b0, cts: 1'b1, exp_count: 16'd5};

        rst = 1'b1;
        cts = 1'b0;
        fc = 1'b0;
        flush = 1'b0;
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        upd_fifo();
        repeat (3) @(negedge clk);
        check("rst_fifo_ren", bus.fifo_ren, 1'b0);
        check("rst_tx_valid", bus.tx_valid, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_sent_count", sent_count, 16'd0);
        check("rst_cts_stall", cts_stall, 1'b0);
        check("rst_idle", idle, 1'b1);
        rst = 1'b0;
        step();

        // Single byte, valid held while the transmitter stalls.
        tx_accept = 1'b0;
        push(8'hA5);
        wait_valid("a5");
        check("a5_ren_pulse", bus.fifo_ren, 1'b1);
        check("a5_tx_data", bus.tx_data, 8'hA5);
        repeat (3) step();
        check("a5_valid_held", bus.tx_valid, 1'b1);
        check("a5_data_held", bus.tx_data, 8'hA5);
        check("a5_one_pop", ren_cnt, 1);
        tx_accept = 1'b1;
        wait_idle("a5");
        check("a5_count", sent_count, 16'd1);
        check("a5_idle", idle, 1'b1);
        check("a5_log", sent_log[$], 8'hA5);

        // Table of single-byte transfers.
        for (int v = 0; v < 4; v++) begin
            fc = vecs[v].fc;
            cts = vecs[v].cts;
            repeat (3) step();
            r0 = ren_cnt;
            push(vecs[v].data);
            wait_idle($sformatf("vec%0d", v));
            check($sformatf("vec%0d_data", v), sent_log[$], vecs[v].data);
            check($sformatf("vec%0d_count", v), sent_count, vecs[v].exp_count);
            check($sformatf("vec%0d_pops", v), ren_cnt - r0, 1);
            check($sformatf("vec%0d_idle", v), idle, 1'b1);
        end

        // Back-to-back bytes.
        fc = 1'b0;
        r0 = ren_cnt;
        l0 = sent_log.size();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_idle("b2b");
        check("b2b_pops", ren_cnt - r0, 3);
        check("b2b_n", sent_log.size() - l0, 3);
        check("b2b_0", sent_log[l0], 8'h11);
        check("b2b_1", sent_log[l0 + 1], 8'h22);
        check("b2b_2", sent_log[l0 + 2], 8'h33);
        check("b2b_turn", acc_cyc[l0 + 1] - acc_cyc[l0], FRAME + 3);
        check("b2b_count", sent_count, 16'd8);

        // CTS blocking, stall flag, release latency.
        fc = 1'b1;
        cts = 1'b0;
        repeat (3) step();
        r0 = ren_cnt;
        push(8'h5A);
        repeat (7) step();
        check("cts_stall_early", cts_stall, 1'b0);
        repeat (2) step();
        check("cts_stall_set", cts_stall, 1'b1);
        check("cts_no_pop", ren_cnt - r0, 0);
        cts = 1'b1;
        step();
        check("cts_ren_c1", bus.fifo_ren, 1'b0);
        step();
        check("cts_ren_c2", bus.fifo_ren, 1'b0);
        step();
        check("cts_ren_c3", bus.fifo_ren, 1'b1);
        wait_idle("cts");
        check("cts_data", sent_log[$], 8'h5A);
        check("cts_count", sent_count, 16'd9);
        check("cts_stall_sticky", cts_stall, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("cts_stall_flushed", cts_stall, 1'b0);
        fc = 1'b0;

        // Flush in LOAD before acceptance discards the byte.
        tx_accept = 1'b0;
        l0 = sent_log.size();
        push(8'h77);
        wait_valid("fl_load");
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_load_valid", bus.tx_valid, 1'b0);
        check("fl_load_idle", idle, 1'b1);
        repeat (3) step();
        check("fl_load_count", sent_count, 16'd9);
        check("fl_load_nolog", sent_log.size() - l0, 0);
        tx_accept = 1'b1;

        // Flush and acceptance on the same edge: byte is sent.
        push(8'h44);
        wait_valid("fl_acc");
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_acc_notidle", idle, 1'b0);
        wait_idle("fl_acc");
        check("fl_acc_count", sent_count, 16'd10);
        check("fl_acc_data", sent_log[$], 8'h44);

        // Flush during SEND does not abort the frame.
        push(8'h88);
        wait_sig("fl_send", 1'b0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_idle("fl_send");
        check("fl_send_count", sent_count, 16'd11);

        // Flush coincident with tx_done still counts.
        push(8'h99);
        wait_sig("fl_done", 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_done_count", sent_count, 16'd12);
        wait_idle("fl_done");

        // Counter wrap.
        force dut.sent_count_d = 16'hFFFF;
        step();
        release dut.sent_count_d;
        check("wrap_pre", sent_count, 16'hFFFF);
        push(8'h01);
        wait_idle("wrap");
        check("wrap_count", sent_count, 16'h0000);

        // Reset during SEND.
        push(8'h02);
        wait_idle("pre_rst");
        c0 = sent_count;
        check("pre_rst_count", c0, 16'h0001);
        push(8'h66);
        wait_sig("rst_send", 1'b0);
        step();
        rst = 1'b1;
        #1;
        check("rsts_fifo_ren", bus.fifo_ren, 1'b0);
        check("rsts_tx_valid", bus.tx_valid, 1'b0);
        check("rsts_tx_data", bus.tx_data, 8'h00);
        check("rsts_count", sent_count, 16'd0);
        check("rsts_stall", cts_stall, 1'b0);
        check("rsts_idle", idle, 1'b1);
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        tx_cnt = 0;
        step();
        rst = 1'b0;
        push(8'h67);
        wait_idle("post_rst");
        check("post_rst_data", sent_log[$], 8'h67);
        check("post_rst_count", sent_count, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
